// File: rtl/maxpool_window_buffer.sv
// rtl/maxpool_window_buffer.sv - 4-channel window assembler feeding the max-pooling stage
module maxpool_window_buffer #(
    parameter int DW        = 8,
    parameter int WIN       = 5,
    parameter int STRIDE    = 5,
    parameter int FRAME_LEN = 180
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in1,
    input  logic [DW-1:0]           in2,
    input  logic [DW-1:0]           in3,
    input  logic [DW-1:0]           in4,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic                    win_last,
    output logic [WIN-1:0][DW-1:0]  win1,
    output logic [WIN-1:0][DW-1:0]  win2,
    output logic [WIN-1:0][DW-1:0]  win3,
    output logic [WIN-1:0][DW-1:0]  win4
);

    localparam int NWIN = (FRAME_LEN - WIN) / STRIDE + 1;
    localparam int USED = (NWIN - 1) * STRIDE + WIN;
    localparam int SW   = $clog2(FRAME_LEN + 1);
    localparam int WW   = $clog2(NWIN + 1);
    localparam int FW   = $clog2(WIN + 1);

    localparam logic [FW-1:0] FILL_FULL  = FW'(WIN);
    localparam logic [FW-1:0] FILL_KEEP  = FW'(WIN - STRIDE);
    localparam logic [FW-1:0] FILL_ONE   = FW'(1);
    localparam logic [WW-1:0] WCNT_LAST  = WW'(NWIN - 1);
    localparam logic [WW-1:0] WCNT_ONE   = WW'(1);
    localparam logic [SW-1:0] SAMP_LAST  = SW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] SAMP_ONE   = SW'(1);
    // Frame length divides exactly into windows: no tail samples to discard.
    localparam logic          NO_DRAIN   = (USED == FRAME_LEN);

    if (STRIDE < 1 || STRIDE > WIN || FRAME_LEN < WIN) begin : g_bad_params
        $error("maxpool_window_buffer: illegal WIN/STRIDE/FRAME_LEN combination");
    end

    typedef enum logic [1:0] {S_FILL, S_OUT, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [SW-1:0]          samp_q, samp_d;
    logic [WW-1:0]          wcnt_q, wcnt_d;
    logic [WIN-1:0][DW-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d, w4_q, w4_d;

    logic accept;
    logic consume;

    assign win_valid = (state_q == S_OUT);
    assign win_last  = win_valid && (wcnt_q == WCNT_LAST);
    assign in_ready  = !rst && (state_q != S_OUT);
    assign accept    = in_valid && in_ready;
    assign consume   = win_valid && win_ready;
    assign win1      = w1_q;
    assign win2      = w2_q;
    assign win3      = w3_q;
    assign win4      = w4_q;

    // Next-state: shift samples in while filling, step window/frame counters on consume.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        samp_d  = samp_q;
        wcnt_d  = wcnt_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        w4_d    = w4_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int i = 0; i < WIN - 1; i++) begin
                        w1_d[i] = w1_q[i+1];
                        w2_d[i] = w2_q[i+1];
                        w3_d[i] = w3_q[i+1];
                        w4_d[i] = w4_q[i+1];
                    end
                    w1_d[WIN-1] = in1;
                    w2_d[WIN-1] = in2;
                    w3_d[WIN-1] = in3;
                    w4_d[WIN-1] = in4;
                    fill_d = fill_q + FILL_ONE;
                    samp_d = samp_q + SAMP_ONE;
                    if (fill_q + FILL_ONE == FILL_FULL) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (consume) begin
                    if (wcnt_q != WCNT_LAST) begin
                        // Overlapping samples stay in the newest slots and shift down.
                        fill_d  = FILL_KEEP;
                        wcnt_d  = wcnt_q + WCNT_ONE;
                        state_d = S_FILL;
                    end else begin
                        fill_d = '0;
                        wcnt_d = '0;
                        if (NO_DRAIN) begin
                            samp_d  = '0;
                            state_d = S_FILL;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    samp_d = samp_q + SAMP_ONE;
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = '0;
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and window registers with synchronous reset discarding partial frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            fill_q  <= '0;
            samp_q  <= '0;
            wcnt_q  <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            w4_q    <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            samp_q  <= samp_d;
            wcnt_q  <= wcnt_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            w4_q    <= w4_d;
        end
    end

endmodule

// File: tb/tb_maxpool_window_buffer.sv
// tb/tb_maxpool_window_buffer.sv - directed checks for maxpool_window_buffer
module tb_maxpool_window_buffer;

    logic clk;
    logic rst;
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [7:0]       in1       [2];
    logic [7:0]       in2       [2];
    logic [7:0]       in3       [2];
    logic [7:0]       in4       [2];
    logic             win_valid [2];
    logic             win_ready [2];
    logic             win_last  [2];
    logic [4:0][7:0]  w1        [2];
    logic [4:0][7:0]  w2        [2];
    logic [4:0][7:0]  w3        [2];
    logic [4:0][7:0]  w4        [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance 0: WIN=5 STRIDE=5 FRAME_LEN=12 (tail drain); instance 1: WIN=5 STRIDE=2 FRAME_LEN=9.
    maxpool_window_buffer #(.DW(8), .WIN(5), .STRIDE(5), .FRAME_LEN(12)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in1(in1[0]), .in2(in2[0]), .in3(in3[0]), .in4(in4[0]),
        .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_last(win_last[0]),
        .win1(w1[0]), .win2(w2[0]), .win3(w3[0]), .win4(w4[0])
    );

    maxpool_window_buffer #(.DW(8), .WIN(5), .STRIDE(2), .FRAME_LEN(9)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in1(in1[1]), .in2(in2[1]), .in3(in3[1]), .in4(in4[1]),
        .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_last(win_last[1]),
        .win1(w1[1]), .win2(w2[1]), .win3(w3[1]), .win4(w4[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] w1, w2, w3, w4;
        logic        last;
    } win_t;

    win_t qa[$];
    win_t qb[$];

    // Inputs change 1 time unit after posedge, so negedge sees the values the next posedge uses.
    always @(negedge clk) begin
        if (!rst && win_valid[0] && win_ready[0]) qa.push_back('{w1[0], w2[0], w3[0], w4[0], win_last[0]});
        if (!rst && win_valid[1] && win_ready[1]) qb.push_back('{w1[1], w2[1], w3[1], w4[1], win_last[1]});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] mkwin(input int first);
        logic [39:0] w;
        for (int i = 0; i < 5; i++) w[i*8 +: 8] = 8'(first + i);
        return w;
    endfunction

    function automatic logic [7:0] lane_byte(input int ch, input logic [7:0] b);
        case (ch)
            2:       return ~b;
            3:       return b + 8'h80;
            4:       return b ^ 8'h5A;
            default: return b;
        endcase
    endfunction

    function automatic logic [39:0] lane(input int ch, input logic [39:0] w);
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = lane_byte(ch, w[i*8 +: 8]);
        return r;
    endfunction

    task automatic drive(input int k, input logic [7:0] d);
        in_valid[k] = 1'b1;
        in1[k] = d;
        in2[k] = lane_byte(2, d);
        in3[k] = lane_byte(3, d);
        in4[k] = lane_byte(4, d);
    endtask

    // Called and returns at posedge+1; holds the sample until accepted, then drops in_valid.
    task automatic feed(input int k, input logic [7:0] d);
        int  c;
        logic got;
        drive(k, d);
        c = 0;
        got = 1'b0;
        while (!got && c < 50) begin
            @(negedge clk);
            got = in_ready[k];
            c++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL feed_timeout: dut %0d sample %0d got in_ready=0 expected 1", k, d);
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic take(input int k, input string nm, input int first, input logic last);
        win_t g;
        int   n;
        n = (k == 0) ? qa.size() : qb.size();
        chk({nm, "_present"}, 64'(n > 0), 64'd1);
        if (n > 0) begin
            if (k == 0) g = qa.pop_front();
            else        g = qb.pop_front();
            chk({nm, "_win1"}, 64'(g.w1), 64'(mkwin(first)));
            chk({nm, "_win2"}, 64'(g.w2), 64'(lane(2, mkwin(first))));
            chk({nm, "_win3"}, 64'(g.w3), 64'(lane(3, mkwin(first))));
            chk({nm, "_win4"}, 64'(g.w4), 64'(lane(4, mkwin(first))));
            chk({nm, "_last"}, 64'(g.last), 64'(last));
        end
    endtask

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        wr;
        logic        e_rdy;
        logic        e_val;
        logic        e_last;
        logic [39:0] e_w1;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; win_ready[k] = 1'b1;
            in1[k] = '0; in2[k] = '0; in3[k] = '0; in4[k] = '0;
        end

        // Scenario 1 / 6 cycle table on instance 0: 1..12 then 21..25, constant side lanes.
        for (int d = 1; d <= 5; d++) tbl.push_back('{1'b1, 8'(d), 1'b1, 1'b1, 1'b0, 1'b0, 40'h0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 40'h0504030201});
        for (int d = 6; d <= 10; d++) tbl.push_back('{1'b1, 8'(d), 1'b1, 1'b1, 1'b0, 1'b0, 40'h0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 40'h0A09080706});
        for (int d = 11; d <= 12; d++) tbl.push_back('{1'b1, 8'(d), 1'b1, 1'b1, 1'b0, 1'b0, 40'h0});
        for (int d = 21; d <= 25; d++) tbl.push_back('{1'b1, 8'(d), 1'b1, 1'b1, 1'b0, 1'b0, 40'h0});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 40'h1918171615});
        tbl.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 40'h0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_a", 64'(in_ready[0]), 64'd0);
        chk("rst_in_ready_b", 64'(in_ready[1]), 64'd0);
        chk("rst_win_valid", 64'(win_valid[0]), 64'd0);
        chk("rst_win_last", 64'(win_last[0]), 64'd0);
        chk("rst_win1", 64'(w1[0]), 64'd0);
        chk("rst_win4", 64'(w4[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid[0] = tbl[i].iv; in1[0] = tbl[i].d; win_ready[0] = tbl[i].wr;
            in2[0] = 8'hFF; in3[0] = 8'h80; in4[0] = 8'h00;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready[0]), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_win_valid", i), 64'(win_valid[0]), 64'(tbl[i].e_val));
            chk($sformatf("tbl%0d_win_last", i), 64'(win_last[0]), 64'(tbl[i].e_last));
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_win1", i), 64'(w1[0]), 64'(tbl[i].e_w1));
                chk($sformatf("tbl%0d_win2", i), 64'(w2[0]), 64'h00FFFFFFFFFF);
                chk($sformatf("tbl%0d_win3", i), 64'(w3[0]), 64'h008080808080);
                chk($sformatf("tbl%0d_win4", i), 64'(w4[0]), 64'h0);
            end
            @(posedge clk);
            #1;
        end
        qa.delete();

        // Rest of frame 2: 26..30 is the last window, 31 and 32 drained.
        for (int d = 26; d <= 32; d++) feed(0, 8'(d));
        take(0, "f2_w1", 26, 1'b1);
        chk("f2_extra", 64'(qa.size()), 64'd0);

        // Scenario 4: one-cycle bubble before every sample; win_valid one cycle after 5th accept.
        for (int d = 1; d <= 12; d++) begin
            @(posedge clk);
            #1;
            feed(0, 8'(d));
            if (d == 5 || d == 10) begin
                @(negedge clk);
                chk($sformatf("bub_latency_%0d", d), 64'(win_valid[0]), 64'd1);
                @(posedge clk);
                #1;
            end
        end
        take(0, "bub_w0", 1, 1'b0);
        take(0, "bub_w1", 6, 1'b1);
        chk("bub_extra", 64'(qa.size()), 64'd0);

        // Scenario 3: consumer stalls 10 cycles while the next sample waits on in_valid.
        win_ready[0] = 1'b0;
        for (int d = 50; d <= 54; d++) feed(0, 8'(d));
        drive(0, 8'd55);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c), 64'(win_valid[0]), 64'd1);
            chk($sformatf("bp%0d_in_ready", c), 64'(in_ready[0]), 64'd0);
            chk($sformatf("bp%0d_win1", c), 64'(w1[0]), 64'(mkwin(50)));
            chk($sformatf("bp%0d_win3", c), 64'(w3[0]), 64'(lane(3, mkwin(50))));
            chk($sformatf("bp%0d_last", c), 64'(win_last[0]), 64'd0);
            @(posedge clk);
            #1;
        end
        win_ready[0] = 1'b1;
        feed(0, 8'd55);
        for (int d = 56; d <= 61; d++) feed(0, 8'(d));
        take(0, "bp_w0", 50, 1'b0);
        take(0, "bp_w1", 55, 1'b1);
        chk("bp_extra", 64'(qa.size()), 64'd0);

        // Scenario 5: reset after three accepted samples discards them.
        for (int d = 70; d <= 72; d++) feed(0, 8'(d));
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", 64'(in_ready[0]), 64'd0);
        chk("mrst_win_valid", 64'(win_valid[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_win1", 64'(w1[0]), 64'd0);
        chk("mrst_win2", 64'(w2[0]), 64'd0);
        chk("mrst_last", 64'(win_last[0]), 64'd0);
        chk("mrst_in_ready_after", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        for (int d = 40; d <= 44; d++) feed(0, 8'(d));
        @(negedge clk);
        @(posedge clk);
        #1;
        take(0, "mrst_w0", 40, 1'b0);
        chk("mrst_extra", 64'(qa.size()), 64'd0);

        // Scenario 2 on instance 1: overlapping windows, no drain, next frame starts at once.
        for (int d = 1; d <= 9; d++) feed(1, 8'(d));
        for (int d = 11; d <= 15; d++) feed(1, 8'(d));
        @(negedge clk);
        @(posedge clk);
        #1;
        take(1, "sl_w0", 1, 1'b0);
        take(1, "sl_w1", 3, 1'b0);
        take(1, "sl_w2", 5, 1'b1);
        take(1, "sl_w3", 11, 1'b0);
        chk("sl_extra", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
